// File: rtl/burst_request_splitter.sv
// burst_request_splitter: splits word transfers into bounded, boundary-aligned bursts; `define BURST_SPLIT_STATS_EN adds transfer/burst counters
module burst_request_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST_LENGTH = 4,
  parameter int LEN_WIDTH = 16,
  parameter int BOUNDARY_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [LEN_WIDTH-1:0]  s_length,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_length,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last_burst,
  output logic                  busy
`ifdef BURST_SPLIT_STATS_EN
  ,
  output logic [15:0]           stat_transfers,
  output logic [15:0]           stat_bursts
`endif
);
  localparam int RW = LEN_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, LOAD, SPLIT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [RW-1:0] remaining;
  logic [RW-1:0] words;
  logic [31:0] to_bnd;
  logic [31:0] cap;
  logic [31:0] rem32;
  logic issue;
  assign s_ready = state == IDLE;
  assign busy = state != IDLE;
  // next burst size: least of words left, burst cap and distance to the next boundary
  always_comb begin
    to_bnd = 32'(BOUNDARY_WORDS) - (32'(cur_addr) & 32'(BOUNDARY_WORDS - 1));
    cap = to_bnd < 32'(MAX_BURST_LENGTH) ? to_bnd : 32'(MAX_BURST_LENGTH);
    rem32 = 32'(remaining);
    words = rem32 < cap ? remaining : RW'(cap);
    issue = state == LOAD || (state == SPLIT && m_ready && !m_last_burst);
  end
  // request latch, burst issue and back-to-back reload on each non-final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      m_addr <= '0;
      m_length <= '0;
      m_valid <= 1'b0;
      m_last_burst <= 1'b0;
    end else begin
      if (state == IDLE && s_valid) begin
        cur_addr <= s_addr;
        remaining <= RW'(s_length) + RW'(1);
        state <= LOAD;
      end
      if (issue) begin
        m_addr <= cur_addr;
        m_length <= 8'(words - RW'(1));
        m_last_burst <= words == remaining;
        m_valid <= 1'b1;
        cur_addr <= cur_addr + ADDR_WIDTH'(words);
        remaining <= remaining - words;
        state <= SPLIT;
      end
      if (state == SPLIT && m_ready && m_last_burst) begin
        m_valid <= 1'b0;
        state <= IDLE;
      end
    end
  end
`ifdef BURST_SPLIT_STATS_EN
  // saturating counts of accepted transfers and delivered bursts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_transfers <= '0;
      stat_bursts <= '0;
    end else begin
      if (s_valid && s_ready && stat_transfers != 16'hFFFF) stat_transfers <= stat_transfers + 16'd1;
      if (m_valid && m_ready && stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_burst_request_splitter.sv
// tb_burst_request_splitter: directed and randomized checks of burst splitting against a word-arithmetic model
module tb_burst_request_splitter;
  localparam int MAXB = 4;
  localparam int BND = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] s_addr = '0;
  logic [15:0] s_length = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] m_addr;
  logic [7:0] m_length;
  logic m_valid;
  logic m_ready = 1'b1;
  logic m_last_burst;
  logic busy;
  int checks = 0;
  int failures = 0;
`ifdef BURST_SPLIT_STATS_EN
  logic [15:0] stat_transfers;
  logic [15:0] stat_bursts;
`endif

  burst_request_splitter dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_addr(s_addr),
    .s_length(s_length),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_addr(m_addr),
    .m_length(m_length),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last_burst(m_last_burst),
    .busy(busy)
`ifdef BURST_SPLIT_STATS_EN
    ,
    .stat_transfers(stat_transfers),
    .stat_bursts(stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] addr, input logic [15:0] len);
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_addr = addr;
    s_length = len;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_addr = $urandom;
    s_length = 16'($urandom);
    @(negedge clk);
    chk("load_m_valid", 64'(m_valid), 64'd0);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_s_ready", 64'(s_ready), 64'd0);
  endtask

  task automatic run_transfer(input logic [31:0] addr, input logic [15:0] len, input int stall_idx, input int stall_n);
    logic [31:0] ea[$];
    logic [7:0] el[$];
    longint a, rem, w;
    int idx, held, n;
    bit done;
    a = longint'(addr);
    rem = longint'(len) + 1;
    while (rem > 0) begin
      w = rem;
      if (w > MAXB) w = MAXB;
      if (w > BND - (a % BND)) w = BND - (a % BND);
      ea.push_back(32'(a));
      el.push_back(8'(w - 1));
      a = (a + w) % 64'h1_0000_0000;
      rem -= w;
    end
    n = ea.size();
    idx = 0;
    held = 0;
    done = 1'b0;
    send(addr, len);
    for (int c = 0; c < 4 * n + 50 && !done; c++) begin
      @(negedge clk);
      if (idx == n) begin
        chk("end_m_valid", 64'(m_valid), 64'd0);
        chk("end_s_ready", 64'(s_ready), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        done = 1'b1;
      end else begin
        chk("burst_m_valid", 64'(m_valid), 64'd1);
        chk("burst_addr", 64'(m_addr), 64'(ea[idx]));
        chk("burst_length", 64'(m_length), 64'(el[idx]));
        chk("burst_last", 64'(m_last_burst), 64'(idx == n - 1));
        chk("burst_busy", 64'(busy), 64'd1);
        m_ready = !(idx == stall_idx && held < stall_n);
        if (m_ready) idx++;
        else held++;
      end
    end
    chk("transfer_complete", 64'(done), 64'd1);
    m_ready = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_length", 64'(m_length), 64'd0);
    chk("rst_m_last", 64'(m_last_burst), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
`ifdef BURST_SPLIT_STATS_EN
    chk("rst_stat_transfers", 64'(stat_transfers), 64'd0);
    chk("rst_stat_bursts", 64'(stat_bursts), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_transfer(32'h0000_0000, 16'd0, -1, 0);
    run_transfer(32'h0000_0010, 16'd9, -1, 0);
    run_transfer(32'h0000_000E, 16'd5, -1, 0);
    run_transfer(32'h0000_0010, 16'd9, 1, 3);
    run_transfer(32'hFFFF_FFFE, 16'd3, -1, 0);
    send(32'h0000_0010, 16'd9);
    @(negedge clk);
    chk("rstmid_first_addr", 64'(m_addr), 64'h10);
    chk("rstmid_first_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    @(posedge clk); #2;
    chk("rstmid_second_addr", 64'(m_addr), 64'h14);
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_valid", 64'(m_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd1);
`ifdef BURST_SPLIT_STATS_EN
    chk("rstmid_stat_transfers", 64'(stat_transfers), 64'd0);
    chk("rstmid_stat_bursts", 64'(stat_bursts), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_m_valid", 64'(m_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    end
    run_transfer(32'h0000_0010, 16'd9, -1, 0);
`ifdef BURST_SPLIT_STATS_EN
    chk("stat_transfers_one", 64'(stat_transfers), 64'd1);
    chk("stat_bursts_three", 64'(stat_bursts), 64'd3);
`endif
    for (int t = 0; t < 25; t++) begin
      logic [31:0] ra;
      ra = $urandom;
      if (t % 3 == 0) ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      run_transfer(ra, 16'($urandom_range(0, 40)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    run_transfer($urandom, 16'hFFFF, int'($urandom_range(0, 100)), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/burst_request_splitter.md
Name: burst_request_splitter

Overview:
Sits directly upstream of burst_read_pipeline and drives its u_addr/u_length/u_valid/u_ready request port. Accepts a transfer request of arbitrary word count and splits it into bursts. Each burst is at most MAX_BURST_LENGTH words and never crosses a BOUNDARY_WORDS-aligned address boundary. Addresses are word addresses: consecutive words differ by 1.

Parameters:
ADDR_WIDTH, 32, word-address width.
MAX_BURST_LENGTH, 4, maximum words per emitted burst; range 1..256.
LEN_WIDTH, 16, width of transfer length field.
BOUNDARY_WORDS, 16, alignment boundary no burst may cross; power of 2, >= MAX_BURST_LENGTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_addr  in  ADDR_WIDTH  transfer start word address
s_length  in  LEN_WIDTH  transfer word count minus 1
s_valid  in  1  transfer request valid
s_ready  out  1  splitter can accept a transfer
m_addr  out  ADDR_WIDTH  burst start address (to u_addr)
m_length  out  8  burst word count minus 1 (to u_length)
m_valid  out  1  burst valid (to u_valid)
m_ready  in  1  downstream accepts burst (from u_ready)
m_last_burst  out  1  burst is final burst of current transfer
busy  out  1  transfer in progress (state != IDLE)

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE, m_valid=0, m_addr=0, m_length=0, m_last_burst=0, busy=0, s_ready=1.
- States:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch cur_addr=s_addr and remaining=s_length+1 (LEN_WIDTH+1 bits, no overflow). Go to LOAD.
  - LOAD: compute the first burst and register it onto m_*. Set m_valid=1 and go to SPLIT. Total latency from acceptance edge to m_valid high is 2 cycles.
  - SPLIT: hold the burst until m_valid&&m_ready.
    - On handshake with m_last_burst=1: m_valid=0, go to IDLE.
    - On handshake otherwise: register the next burst on the same edge, so bursts go out back-to-back with no bubble.
- Burst size: words = min(remaining, MAX_BURST_LENGTH, BOUNDARY_WORDS - (cur_addr mod BOUNDARY_WORDS)).
  - m_length = words-1, truncated to 8 bits.
  - After each burst is issued: cur_addr += words (mod 2^ADDR_WIDTH), remaining -= words.
  - m_last_burst = (words == remaining) for that burst.
- Handshake rules:
  - s_ready is combinational (state==IDLE) and does not depend on s_valid.
  - m_valid is never deasserted without a handshake.
  - m_addr, m_length and m_last_burst stay stable while m_valid&&!m_ready.
  - m_valid does not depend combinationally on m_ready.
- Boundaries:
  - s_length=0 produces one burst with m_length=0.
  - The address wraps at 2^ADDR_WIDTH with no error; 0 is a boundary.
  - s_length=2^LEN_WIDTH-1 is legal; remaining needs the extra bit.
  - The next transfer is accepted no earlier than the cycle after the final handshake. The minimum inter-transfer gap is IDLE+LOAD.
- Reset mid-operation: every pending burst is discarded and m_valid falls immediately (asynchronous). After reset release the block is in IDLE with s_ready=1.

Optional Feature:
BURST_SPLIT_STATS_EN
- Defined: adds output ports stat_transfers[15:0] and stat_bursts[15:0].
  - stat_transfers increments on each s_valid&&s_ready.
  - stat_bursts increments on each m_valid&&m_ready.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
All scenarios use defaults MAX_BURST_LENGTH=4, BOUNDARY_WORDS=16, m_ready=1 unless stated.
1. s_addr=0x00, s_length=0 -> one burst (m_addr=0x00, m_length=0, m_last_burst=1); m_valid high 2 cycles after acceptance; s_ready high again the cycle after handshake.
2. s_addr=0x10, s_length=9 -> bursts (0x10,3), (0x14,3), (0x18,1) on consecutive cycles; m_last_burst=1 only on third.
3. s_addr=0x0E, s_length=5 -> bursts (0x0E,1), (0x10,3): split at boundary 0x10.
4. Scenario 2 with m_ready=0 for 3 cycles while (0x14,3) is presented -> m_addr=0x14, m_length=3, m_valid=1 held stable all 3 cycles; third burst still 0x18; no loss or duplication.
5. s_addr=0xFFFFFFFE, s_length=3 -> bursts (0xFFFFFFFE,1), (0x00000000,1) with last on second; busy=1 throughout.
6. rst_n pulsed low after first handshake of scenario 2 -> m_valid=0 during reset; after release s_ready=1, busy=0, and no burst 0x14/0x18 appears. With BURST_SPLIT_STATS_EN: counters read 0 after reset; after a full run of scenario 2, stat_transfers=1 and stat_bursts=3.
